sub_nbit_serial: RTL and testbench

Multi-cycle nibble-serial subtractor: computes `A - B - borrow` over a `DATA_WIDTH`-bit operand pair, one 4-bit chunk per clock. It mirrors the 4-bit carry-lookahead adder, which is the other direction of the same arithmetic path. Each nibble step is `a + ~b + carry`, with the chain seeded by `~i_brw`. The block sits in the calc/sub path behind a valid/ready handshake on both sides, so an ALU sequencer can trade latency for area.

---
 rtl/sub_nbit_serial.sv | 142 ++++++++++++++
 tb/tb_sub_nbit_serial.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_nbit_serial.sv
// sub_nbit_serial: nibble-serial subtractor computing A - B - brw over
// DATA_WIDTH bits, one 4-bit carry-lookahead step per clock, with valid/ready
// handshakes on the request and result sides. DATA_WIDTH must be a multiple
// of 4 and at least 4.
module sub_nbit_serial #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_brw,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_brw,
    output logic                  o_ovf
);

    localparam int N     = DATA_WIDTH / 4;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_r;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] b_r;
    logic [DATA_WIDTH-1:0] acc_r;
    logic                  carry_r;
    logic [CNT_W-1:0]      cnt_r;

    logic [3:0]            a_nib_s;
    logic [3:0]            b_nib_s;
    logic [4:0]            sum_s;
    logic [DATA_WIDTH-1:0] acc_next_s;
    logic                  ovf_s;

    // 4-bit carry-lookahead add returning {carry_out, sum}.
    function automatic logic [4:0] cla_nibble(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       cin
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    // o_ready depends only on the state register, never on i_valid/i_ready.
    assign o_ready = (state_r == ST_IDLE);

    // Select the current nibble, add it, and merge the sum into the accumulator.
    always_comb begin
        a_nib_s    = 4'h0;
        b_nib_s    = 4'h0;
        acc_next_s = acc_r;
        for (int i = 0; i < N; i++) begin
            a_nib_s = a_nib_s | (a_r[4*i +: 4] & {4{cnt_r == CNT_W'(i)}});
            b_nib_s = b_nib_s | (b_r[4*i +: 4] & {4{cnt_r == CNT_W'(i)}});
        end
        // Subtraction as a + ~b + carry; the carry chain was seeded with ~brw.
        sum_s = cla_nibble(a_nib_s, ~b_nib_s, carry_r);
        for (int i = 0; i < N; i++) begin
            acc_next_s[4*i +: 4] = (cnt_r == CNT_W'(i)) ? sum_s[3:0] : acc_r[4*i +: 4];
        end
        // Signed overflow: operands differ in sign and the result sign leaves A's.
        ovf_s = (a_r[DATA_WIDTH-1] ^ b_r[DATA_WIDTH-1])
              & (acc_next_s[DATA_WIDTH-1] ^ a_r[DATA_WIDTH-1]);
    end

    // Control FSM, operand latches, nibble datapath state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            o_valid <= 1'b0;
            o_res   <= '0;
            o_brw   <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_r     <= i_num_a;
                        b_r     <= i_num_b;
                        carry_r <= ~i_brw;
                        cnt_r   <= '0;
                        state_r <= ST_CALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_r   <= acc_next_s;
                    carry_r <= sum_s[4];
                    if (cnt_r == LAST_CNT) begin
                        // Counter holds at N-1; it is cleared on the next accept.
                        o_res   <= acc_next_s;
                        o_brw   <= ~sum_s[4];
                        o_ovf   <= ovf_s;
                        o_valid <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_nbit_serial.sv
// Testbench for sub_nbit_serial (DATA_WIDTH=16): directed vectors, random
// operations against an arithmetic reference model, backpressure and resets.
module tb_sub_nbit_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [15:0] num_a;
    logic [15:0] num_b;
    logic        brw_in;
    logic        valid_out;
    logic        ready_in;
    logic [15:0] res;
    logic        brw_out;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    sub_nbit_serial #(.DATA_WIDTH(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .i_num_a (num_a),
        .i_num_b (num_b),
        .i_brw   (brw_in),
        .o_valid (valid_out),
        .i_ready (ready_in),
        .o_res   (res),
        .o_brw   (brw_out),
        .o_ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic, returns {borrow, overflow, result}.
    function automatic logic [17:0] model_sub(input logic [15:0] a, input logic [15:0] b,
                                              input logic br);
        int unsigned ai;
        int unsigned bi;
        int unsigned diff;
        logic [15:0] r;
        logic        bo;
        logic        ov;
        ai   = a;
        bi   = b;
        diff = ai - bi - br;
        r    = diff[15:0];
        bo   = (ai < bi + br);
        ov   = (a[15] != b[15]) && (r[15] != a[15]);
        return {bo, ov, r};
    endfunction

    // Drive one request from IDLE and wait (bounded) for o_valid. After the
    // accept edge the operand inputs are scrambled to show they are ignored.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic br,
                          output logic [15:0] r, output logic rb, output logic ro,
                          output int lat, output bit timed_out);
        @(negedge clk);
        num_a    = a;
        num_b    = b;
        brw_in   = br;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        num_a     = 16'($urandom);
        num_b     = 16'($urandom);
        brw_in    = 1'($urandom);
        lat       = 0;
        timed_out = 1'b1;
        r = 16'h0; rb = 1'b0; ro = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (valid_out === 1'b1) begin
                lat = k; timed_out = 1'b0;
                r = res; rb = brw_out; ro = ovf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        valid_in = 1'b1;
        ready_in = 1'b1;
        num_a    = 16'h1234;
        num_b    = 16'h0001;
        brw_in   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        checks++;
        if (res !== 16'h0000) begin errors++; $display("FAIL reset_res: got %h expected 0000", res); end
        checks++;
        if (brw_out !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_flags: got brw=%b ovf=%b expected 0 0", brw_out, ovf); end
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got ready=%b valid=%b expected 1 0", ready_out, valid_out); end
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'h1234, 16'h0000, 16'h0005, 16'h8000, 16'h7FFF};
        logic [15:0] vb [5] = '{16'h0234, 16'h0001, 16'h0005, 16'h0001, 16'hFFFF};
        logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] er [5] = '{16'h1000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic        eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] r;
        logic        rb;
        logic        ro;
        int          lat;
        bit          to;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], r, rb, ro, lat, to);
            checks++;
            if (to || lat != 4) begin errors++; $display("FAIL directed%0d_latency: got %0d (timeout=%0d) expected 4", i, lat, to); end
            checks++;
            if (r !== er[i] || rb !== eb[i] || ro !== eo[i]) begin
                errors++;
                $display("FAIL directed%0d_result: got res=%h brw=%b ovf=%b expected res=%h brw=%b ovf=%b",
                         i, r, rb, ro, er[i], eb[i], eo[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic        br;
        logic [17:0] exp;
        logic [15:0] r;
        logic        rb;
        logic        ro;
        int          lat;
        bit          to;
        for (int i = 0; i < 40; i++) begin
            a   = 16'($urandom);
            b   = (i % 8 == 0) ? a : 16'($urandom);
            br  = 1'($urandom);
            exp = model_sub(a, b, br);
            run_op(a, b, br, r, rb, ro, lat, to);
            checks++;
            if (to || {rb, ro, r} !== exp || lat != 4) begin
                errors++;
                $display("FAIL random%0d: a=%h b=%h brw=%b got res=%h brw=%b ovf=%b lat=%0d expected res=%h brw=%b ovf=%b lat=4",
                         i, a, b, br, r, rb, ro, lat, exp[15:0], exp[17], exp[16]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL random%0d_release: got ready=%b valid=%b expected 1 0", i, ready_out, valid_out);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a;
        logic [15:0] b;
        logic [17:0] exp;
        logic [15:0] r;
        logic        rb;
        logic        ro;
        int          lat;
        bit          to;
        a        = 16'($urandom);
        b        = 16'($urandom);
        exp      = model_sub(a, b, 1'b1);
        ready_in = 1'b0;
        run_op(a, b, 1'b1, r, rb, ro, lat, to);
        checks++;
        if (to || {rb, ro, r} !== exp) begin
            errors++;
            $display("FAIL bp_result: got res=%h brw=%b ovf=%b expected res=%h brw=%b ovf=%b",
                     r, rb, ro, exp[15:0], exp[17], exp[16]);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            num_a    = 16'($urandom);
            num_b    = 16'($urandom);
            valid_in = 1'($urandom) | (k == 2);
            @(posedge clk);
            #1;
            checks++;
            if (valid_out !== 1'b1 || ready_out !== 1'b0 || {brw_out, ovf, res} !== exp) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b ready=%b res=%h brw=%b ovf=%b expected 1 0 res=%h brw=%b ovf=%b",
                         k, valid_out, ready_out, res, brw_out, ovf, exp[15:0], exp[17], exp[16]);
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", valid_out, ready_out); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin errors++; $display("FAIL bp_no_queue: got valid=%b ready=%b expected 0 1", valid_out, ready_out); end
    endtask

    task automatic test_reset_mid_calc();
        bit          seen;
        logic [15:0] r;
        logic        rb;
        logic        ro;
        int          lat;
        bit          to;
        @(negedge clk);
        num_a    = 16'h4321;
        num_b    = 16'h1111;
        brw_in   = 1'b0;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (valid_out !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midreset_no_valid: got valid seen=1 expected 0"); end
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", ready_out); end
        run_op(16'hFFFF, 16'h0000, 1'b1, r, rb, ro, lat, to);
        checks++;
        if (to || r !== 16'hFFFE || rb !== 1'b0 || ro !== 1'b0 || lat != 4) begin
            errors++;
            $display("FAIL midreset_fresh: got res=%h brw=%b ovf=%b lat=%0d expected res=fffe brw=0 ovf=0 lat=4", r, rb, ro, lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
